mac_col_array: RTL and testbench
================================

MAC_COL_ARRAY -- requirements
Module: mac_col_array

Interface
REQ-001 SHALL have parameter bw, default 8: Q/K element bit width.
REQ-002 SHALL have parameter bw_psum, default 2*bw+4: output partial-sum width per column.
REQ-003 SHALL have parameter pr, default 16: number of products per dot product.
REQ-004 SHALL have parameter col, default 4, range 1..16: number of K columns.
REQ-005 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1: synchronous, active-low reset (0 = reset).
REQ-007 SHALL have port q_in  input  pr*bw: element j in bits [(j+1)*bw-1 : j*bw]; carries a K vector in load cycles and a Q vector in stream cycles.
REQ-008 SHALL have port i_inst  input  2: bit0 = K load, bit1 = Q stream.
REQ-009 SHALL have port k_sel  input  max(1,$clog2(col)): column targeted by a K load.
REQ-010 SHALL have port sgn  input  1: 1 = two's-complement operands, 0 = unsigned.
REQ-011 SHALL have port acc  input  1: 1 = accumulate successive results, 0 = overwrite.
REQ-012 SHALL have port out  output  col*bw_psum: column c result in bits [(c+1)*bw_psum-1 : c*bw_psum].
REQ-013 SHALL have port o_valid  output  1: out holds a new result this cycle.
REQ-014 SHALL have port o_inst  output  2: i_inst delayed by one cycle, for chaining.

Function
REQ-015 SHALL, on a cycle with i_inst[0]=1, store q_in into K register bank k_sel; the other banks are unchanged.
REQ-016 SHALL ignore a k_sel value >= col: no bank is written.
REQ-017 SHALL, when i_inst = 2'b11, perform the K load only; the cycle is not a stream cycle and produces no o_valid.
REQ-018 SHALL treat a cycle with i_inst = 2'b10 as a stream cycle: Q = q_in is broadcast to all columns.
REQ-019 SHALL be a two-stage pipeline:
- stage 1 registers the pr products for every column;
- stage 2 registers the adder-tree sum into out.
REQ-020 SHALL assert o_valid exactly 2 cycles after each stream cycle, for one cycle per stream cycle; back-to-back stream cycles give back-to-back valids.
REQ-021 SHALL sample sgn and acc with the stream cycle and carry them through the pipeline alongside the data; a mid-stream change affects only later vectors.
REQ-022 SHALL, when sgn=1, sign-extend the products to bw_psum; when sgn=0, zero-extend them.
REQ-023 SHALL compute each sum modulo 2^bw_psum (wrap, no saturation).
REQ-024 SHALL, when acc=0, load out with the new sum.
REQ-025 SHALL, when acc=1, load out with out + new sum (modulo 2^bw_psum), except on the first stream cycle after i_inst[1] rises, which loads the sum unaccumulated.
REQ-026 SHALL hold out and keep o_valid=0 in non-stream cycles.
REQ-027 SHALL use the K values held at the stream cycle's edge; a K load in the same cycle as a stream into another bank is not possible (REQ-017).
REQ-028 SHALL register o_inst from i_inst every cycle.

Reset
REQ-029 SHALL, on a cycle with reset=0, clear all of the following, overriding any instruction:
- the K banks, pipeline registers and accumulation flag;
- out=0, o_valid=0, o_inst=0.
REQ-030 SHALL discard in-flight results when reset is asserted mid-stream; no o_valid appears for vectors streamed up to and including the reset cycle.
REQ-031 SHALL resume normal operation on the first edge with reset=1.

Verification
REQ-032 Unsigned dot product:
- stimulus: load column 0 with all K=1, sgn=0, acc=0, stream Q all 2;
- response: 2 cycles later o_valid=1, out column 0 = 0x00020, other columns = 0.
REQ-033 Sign mode:
- stimulus: load column 1 with K all 0xFF, stream Q all 1, once with sgn=1 and once with sgn=0;
- response: sgn=1 gives column 1 = 0xFFFF0 (-16); sgn=0 gives 0x00FF0 (4080).
REQ-034 Accumulate:
- stimulus: K all 1 in every column, acc=1, stream three Q vectors of all 1 back-to-back;
- response: valid on 3 consecutive cycles with each column = 16, 32, 48;
- a new burst after i_inst[1] falls restarts at 16.
REQ-035 Contention and bounds:
- stimulus: i_inst=2'b11 with k_sel=2;
- response: column 2 loads, no o_valid two cycles later;
- stimulus: k_sel=col;
- response: no bank changes.
REQ-036 Reset mid-stream:
- stimulus: stream 4 vectors, drive reset=0 on the 2nd;
- response: out=0 and o_valid=0 from the next edge, no valids for vectors 1-2, and vectors 3-4 produce results with all K=0, so out=0 with o_valid=1.
REQ-037 Random regression:
- stimulus: 8 random Q vectors, pr=16, col=4, both sgn values;
- response: each out matches a reference model of sum(Q*K) mod 2^20 at latency 2.

Source files
------------

// File: rtl/mac_col_array.sv
// mac_col_array: column array of pr-wide dot-product engines sharing one Q
// vector per stream cycle. Each column holds its own K vector.
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous active-low reset
//   q_in     pr elements of bw bits: K vector on loads, Q vector on streams
//   i_inst   bit0 = K load into bank k_sel, bit1 = Q stream (2'b11 = load only)
//   k_sel    target K bank for a load; values >= col are ignored
//   sgn      1 = two's-complement operands, 0 = unsigned (sampled per stream)
//   acc      1 = accumulate into out, 0 = overwrite (sampled per stream)
//   out      col results of bw_psum bits, column c at [(c+1)*bw_psum-1 : c*bw_psum]
//   o_valid  out was updated by a stream issued two cycles earlier
//   o_inst   i_inst delayed one cycle
module mac_col_array #(
    parameter int bw      = 8,
    parameter int bw_psum = 2*bw+4,
    parameter int pr      = 16,
    parameter int col     = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [pr*bw-1:0]                        q_in,
    input  logic [1:0]                              i_inst,
    input  logic [((col > 1) ? $clog2(col) : 1)-1:0] k_sel,
    input  logic                                    sgn,
    input  logic                                    acc,
    output logic [col*bw_psum-1:0]                  out,
    output logic                                    o_valid,
    output logic [1:0]                              o_inst
);

    localparam int unsigned pw = 2 * bw;

    logic [col-1:0][pr*bw-1:0]        k_bank;
    logic [col-1:0][pr-1:0][pw-1:0]   prod_d;
    logic [col-1:0][pr-1:0][pw-1:0]   prod_q;
    logic [col-1:0][bw_psum-1:0]      sum_d;
    logic [col-1:0][bw_psum-1:0]      out_q;
    logic                             s1_valid;
    logic                             s1_sgn;
    logic                             s1_acc;
    logic                             burst_on;
    logic                             stream_c;

    // A load+stream cycle is treated as a load only.
    assign stream_c = (i_inst == 2'b10);
    assign out      = out_q;

    // Per-element products; operands are widened first so the product keeps all 2*bw bits.
    always_comb begin
        logic [bw-1:0] qe;
        logic [bw-1:0] ke;
        prod_d = '0;
        qe     = '0;
        ke     = '0;
        for (int c = 0; c < col; c++) begin
            for (int j = 0; j < pr; j++) begin
                qe = q_in[j*bw +: bw];
                ke = k_bank[c][j*bw +: bw];
                if (sgn) begin
                    prod_d[c][j] = $signed({{bw{qe[bw-1]}}, qe}) * $signed({{bw{ke[bw-1]}}, ke});
                end else begin
                    prod_d[c][j] = {{bw{1'b0}}, qe} * {{bw{1'b0}}, ke};
                end
            end
        end
    end

    // Adder tree over the registered products, extended per the sign mode carried with them.
    always_comb begin
        sum_d = '0;
        for (int c = 0; c < col; c++) begin
            for (int j = 0; j < pr; j++) begin
                if (s1_sgn) begin
                    sum_d[c] = sum_d[c] + bw_psum'($signed(prod_q[c][j]));
                end else begin
                    sum_d[c] = sum_d[c] + bw_psum'(prod_q[c][j]);
                end
            end
        end
    end

    // Stage 1: K banks, product registers and per-vector control.
    always_ff @(posedge clk) begin
        if (!reset) begin
            k_bank   <= '0;
            prod_q   <= '0;
            s1_valid <= 1'b0;
            s1_sgn   <= 1'b0;
            s1_acc   <= 1'b0;
            burst_on <= 1'b0;
            o_inst   <= 2'b00;
        end else begin
            o_inst   <= i_inst;
            burst_on <= i_inst[1];
            s1_valid <= stream_c;
            if (stream_c) begin
                prod_q <= prod_d;
                s1_sgn <= sgn;
                // First stream after i_inst[1] rises never accumulates.
                s1_acc <= acc & burst_on;
            end
            for (int c = 0; c < col; c++) begin
                if (i_inst[0] && (int'(k_sel) == c)) begin
                    k_bank[c] <= q_in;
                end
            end
        end
    end

    // Stage 2: result registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q   <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                for (int c = 0; c < col; c++) begin
                    out_q[c] <= s1_acc ? (out_q[c] + sum_d[c]) : sum_d[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_col_array.sv
module tb_mac_col_array;

    localparam int BW  = 8;
    localparam int PSW = 20;
    localparam int PR  = 16;
    localparam int COL = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [PR*BW-1:0]    q_in;
    logic [1:0]          i_inst;
    logic [1:0]          k_sel;
    logic                sgn;
    logic                acc;
    logic [COL*PSW-1:0]  out;
    logic                o_valid;
    logic [1:0]          o_inst;
    logic [3*PSW-1:0]    out3;
    logic                o_valid3;
    logic [1:0]          o_inst3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mac_col_array #(.bw(BW), .bw_psum(PSW), .pr(PR), .col(COL)) dut (
        .clk(clk), .reset(reset), .q_in(q_in), .i_inst(i_inst), .k_sel(k_sel),
        .sgn(sgn), .acc(acc), .out(out), .o_valid(o_valid), .o_inst(o_inst)
    );

    // Three-column instance so that k_sel = col is representable.
    mac_col_array #(.bw(BW), .bw_psum(PSW), .pr(PR), .col(3)) dut3 (
        .clk(clk), .reset(reset), .q_in(q_in), .i_inst(i_inst), .k_sel(k_sel),
        .sgn(sgn), .acc(acc), .out(out3), .o_valid(o_valid3), .o_inst(o_inst3)
    );

    function automatic logic [PR*BW-1:0] fill(input logic [BW-1:0] v);
        logic [PR*BW-1:0] r;
        r = '0;
        for (int j = 0; j < PR; j++) r[j*BW +: BW] = v;
        return r;
    endfunction

    function automatic logic [PSW-1:0] ref_dot(input logic [PR*BW-1:0] q,
                                              input logic [PR*BW-1:0] k,
                                              input logic s);
        int          total;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        total = 0;
        for (int j = 0; j < PR; j++) begin
            a = q[j*BW +: BW];
            b = k[j*BW +: BW];
            if (s) total += int'($signed(a)) * int'($signed(b));
            else   total += int'(a) * int'(b);
        end
        return PSW'(total);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_k(input int c, input logic [PR*BW-1:0] v);
        i_inst = 2'b01;
        k_sel  = 2'(c);
        q_in   = v;
        tick();
        i_inst = 2'b00;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        i_inst = 2'b11;
        k_sel  = 2'd0;
        q_in   = fill(8'h7F);
        tick();
        tick();
        n_checks++;
        if (out !== '0) begin n_fail++; $display("FAIL reset_out: got %h expected 0", out); end
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        n_checks++;
        if (o_inst !== 2'b00) begin n_fail++; $display("FAIL reset_oinst: got %b expected 00", o_inst); end
        reset  = 1'b1;
        i_inst = 2'b00;
        tick();
    endtask

    task automatic test_unsigned();
        logic [PSW-1:0] exp_v;
        load_k(0, fill(8'd1));
        i_inst = 2'b10; q_in = fill(8'd2); sgn = 1'b0; acc = 1'b0;
        tick();
        n_checks++;
        if (o_inst !== 2'b10) begin n_fail++; $display("FAIL unsigned_oinst: got %b expected 10", o_inst); end
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL unsigned_early_valid: got %b expected 0", o_valid); end
        i_inst = 2'b00;
        tick();
        n_checks++;
        if (o_valid !== 1'b1) begin n_fail++; $display("FAIL unsigned_valid: got %b expected 1", o_valid); end
        for (int c = 0; c < COL; c++) begin
            exp_v = (c == 0) ? 20'h00020 : 20'h0;
            n_checks++;
            if (out[c*PSW +: PSW] !== exp_v) begin
                n_fail++; $display("FAIL unsigned_col%0d: got %h expected %h", c, out[c*PSW +: PSW], exp_v);
            end
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL unsigned_valid_drop: got %b expected 0", o_valid); end
        n_checks++;
        if (out[0 +: PSW] !== 20'h00020) begin n_fail++; $display("FAIL unsigned_hold: got %h expected 00020", out[0 +: PSW]); end
    endtask

    task automatic test_sign();
        load_k(1, fill(8'hFF));
        i_inst = 2'b10; q_in = fill(8'd1); acc = 1'b0; sgn = 1'b1;
        tick();
        sgn = 1'b0;
        tick();
        n_checks++;
        if (o_valid !== 1'b1) begin n_fail++; $display("FAIL sign_valid1: got %b expected 1", o_valid); end
        n_checks++;
        if (out[PSW +: PSW] !== 20'hFFFF0) begin n_fail++; $display("FAIL sign_signed: got %h expected FFFF0", out[PSW +: PSW]); end
        i_inst = 2'b00;
        tick();
        n_checks++;
        if (o_valid !== 1'b1) begin n_fail++; $display("FAIL sign_valid2: got %b expected 1", o_valid); end
        n_checks++;
        if (out[PSW +: PSW] !== 20'h00FF0) begin n_fail++; $display("FAIL sign_unsigned: got %h expected 00FF0", out[PSW +: PSW]); end
    endtask

    task automatic test_accumulate();
        logic [PSW-1:0] exp_v;
        for (int c = 0; c < COL; c++) load_k(c, fill(8'd1));
        i_inst = 2'b10; q_in = fill(8'd1); sgn = 1'b0; acc = 1'b1;
        tick();
        for (int step = 1; step <= 3; step++) begin
            if (step == 3) i_inst = 2'b00;
            tick();
            exp_v = PSW'(16 * step);
            n_checks++;
            if (o_valid !== 1'b1) begin n_fail++; $display("FAIL acc_valid%0d: got %b expected 1", step, o_valid); end
            for (int c = 0; c < COL; c++) begin
                n_checks++;
                if (out[c*PSW +: PSW] !== exp_v) begin
                    n_fail++; $display("FAIL acc_step%0d_col%0d: got %h expected %h", step, c, out[c*PSW +: PSW], exp_v);
                end
            end
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL acc_gap_valid: got %b expected 0", o_valid); end
        n_checks++;
        if (out[0 +: PSW] !== 20'd48) begin n_fail++; $display("FAIL acc_gap_hold: got %h expected 30", out[0 +: PSW]); end
        i_inst = 2'b10;
        tick();
        i_inst = 2'b00;
        tick();
        n_checks++;
        if (o_valid !== 1'b1) begin n_fail++; $display("FAIL acc_restart_valid: got %b expected 1", o_valid); end
        for (int c = 0; c < COL; c++) begin
            n_checks++;
            if (out[c*PSW +: PSW] !== 20'd16) begin
                n_fail++; $display("FAIL acc_restart_col%0d: got %h expected 10", c, out[c*PSW +: PSW]);
            end
        end
    endtask

    task automatic test_contention();
        logic [PSW-1:0] exp4 [COL];
        logic [PSW-1:0] exp3 [3];
        exp4 = '{20'd16, 20'd16, 20'd48, 20'd80};
        exp3 = '{20'd16, 20'd16, 20'd48};
        acc = 1'b0; sgn = 1'b0;
        i_inst = 2'b11; k_sel = 2'd2; q_in = fill(8'd3);
        tick();
        i_inst = 2'b00;
        tick();
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL both_valid_a: got %b expected 0", o_valid); end
        tick();
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL both_valid_b: got %b expected 0", o_valid); end
        load_k(3, fill(8'd5));
        i_inst = 2'b10; q_in = fill(8'd1);
        tick();
        i_inst = 2'b00;
        tick();
        n_checks++;
        if (o_valid3 !== 1'b1) begin n_fail++; $display("FAIL bounds_valid: got %b expected 1", o_valid3); end
        for (int c = 0; c < COL; c++) begin
            n_checks++;
            if (out[c*PSW +: PSW] !== exp4[c]) begin
                n_fail++; $display("FAIL load_col%0d: got %h expected %h", c, out[c*PSW +: PSW], exp4[c]);
            end
        end
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (out3[c*PSW +: PSW] !== exp3[c]) begin
                n_fail++; $display("FAIL bounds_col%0d: got %h expected %h", c, out3[c*PSW +: PSW], exp3[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        acc = 1'b0; sgn = 1'b0;
        i_inst = 2'b10; q_in = fill(8'd1);
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (out !== '0) begin n_fail++; $display("FAIL midrst_out: got %h expected 0", out); end
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", o_valid); end
        reset = 1'b1;
        tick();
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_lost: got %b expected 0", o_valid); end
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || out !== '0) begin
            n_fail++; $display("FAIL midrst_v3: got valid %b out %h expected valid 1 out 0", o_valid, out);
        end
        i_inst = 2'b00;
        tick();
        n_checks++;
        if (o_valid !== 1'b1 || out !== '0) begin
            n_fail++; $display("FAIL midrst_v4: got valid %b out %h expected valid 1 out 0", o_valid, out);
        end
    endtask

    task automatic test_random();
        logic [PR*BW-1:0] kv [COL];
        logic [PR*BW-1:0] rq [8];
        logic             rs [8];
        logic [PSW-1:0]   exp_v;
        for (int c = 0; c < COL; c++) begin
            for (int j = 0; j < PR; j++) kv[c][j*BW +: BW] = 8'($urandom);
            load_k(c, kv[c]);
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < PR; j++) rq[i][j*BW +: BW] = 8'($urandom);
            rs[i] = 1'(i % 2);
        end
        acc = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                i_inst = 2'b10; q_in = rq[i]; sgn = rs[i];
            end else begin
                i_inst = 2'b00;
            end
            tick();
            if (i >= 1) begin
                n_checks++;
                if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rand%0d_valid: got %b expected 1", i-1, o_valid); end
                for (int c = 0; c < COL; c++) begin
                    exp_v = ref_dot(rq[i-1], kv[c], rs[i-1]);
                    n_checks++;
                    if (out[c*PSW +: PSW] !== exp_v) begin
                        n_fail++; $display("FAIL rand%0d_col%0d: got %h expected %h", i-1, c, out[c*PSW +: PSW], exp_v);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0; i_inst = 2'b00; k_sel = 2'd0; q_in = '0; sgn = 1'b0; acc = 1'b0;
        test_reset();
        test_unsigned();
        test_sign();
        test_accumulate();
        test_contention();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
